// File: rtl/demux1to8_tdm.sv
`default_nettype none
// ============================================================================
//  Module      : demux1to8_tdm
//  Description : 1-to-8 TDM serial demultiplexer. Serial bits are collected
//                into eight one-bit slots aligned by frame_sync. Each
//                completed frame is presented in parallel on out, together
//                with a one-cycle out_valid pulse.
//                Optional macro DEMUX_SYNC_STRICT_EN: when defined, every
//                frame must start with frame_sync. A missing sync at slot 0
//                drops lock (strict mode). When undefined, the block
//                flywheels and frame_sync is optional once locked.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1to8_tdm (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       frame_sync,
    output logic [7:0] out,
    output logic       out_valid,
    output logic [2:0] slot,
    output logic       locked,
    output logic       sync_err
);

    localparam logic [0:0] c_HUNT   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;
    localparam logic [2:0] c_LAST   = 3'd7;

    logic [0:0] r_state;
    logic [2:0] r_slot;
    logic [6:0] r_shadow;      // bits of slots 0..6; slot 7 goes straight to out
    logic [7:0] r_out;
    logic       r_out_valid;
    logic       r_sync_err;

    logic [0:0] w_state_n;
    logic [2:0] w_slot_n;
    logic [6:0] w_shadow_n;
    logic [7:0] w_out_n;
    logic       w_out_valid_n;
    logic       w_sync_err_n;

    // Next-state decode: frame alignment, slot advance and frame completion.
    always_comb begin
        w_state_n     = r_state;
        w_slot_n      = r_slot;
        w_shadow_n    = r_shadow;
        w_out_n       = r_out;
        w_out_valid_n = 1'b0;
        w_sync_err_n  = 1'b0;

        case (r_state)
            c_HUNT: begin
                // Only a sync-marked bit can open a frame; everything else is dropped.
                if (din_valid && frame_sync) begin
                    w_state_n  = c_LOCKED;
                    w_shadow_n = {6'b0, din};
                    w_slot_n   = 3'd1;
                end
            end

            c_LOCKED: begin
                if (din_valid) begin
                    if (frame_sync && (r_slot != 3'd0)) begin
                        // Misaligned sync: drop the partial frame and restart at slot 0.
                        w_sync_err_n = 1'b1;
                        w_shadow_n   = {6'b0, din};
                        w_slot_n     = 3'd1;
                    end
`ifdef DEMUX_SYNC_STRICT_EN
                    else if (!frame_sync && (r_slot == 3'd0)) begin
                        // Every frame must carry its own sync; losing it drops lock.
                        w_sync_err_n = 1'b1;
                        w_state_n    = c_HUNT;
                        w_slot_n     = 3'd0;
                        w_shadow_n   = 7'b0;
                    end
`endif
                    else if (r_slot == c_LAST) begin
                        // Final slot: publish the whole frame in one step.
                        w_out_n       = {din, r_shadow};
                        w_out_valid_n = 1'b1;
                        w_slot_n      = 3'd0;
                    end else begin
                        for (int k = 0; k < 7; k++) begin
                            if (r_slot == 3'(k)) begin
                                w_shadow_n[k] = din;
                            end
                        end
                        w_slot_n = r_slot + 3'd1;
                    end
                end
            end

            default: begin
                w_state_n = c_HUNT;
                w_slot_n  = 3'd0;
            end
        endcase
    end

    // State registers; reset overrides every input in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_HUNT;
            r_slot      <= 3'd0;
            r_shadow    <= 7'b0;
            r_out       <= 8'h00;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_slot      <= w_slot_n;
            r_shadow    <= w_shadow_n;
            r_out       <= w_out_n;
            r_out_valid <= w_out_valid_n;
            r_sync_err  <= w_sync_err_n;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign slot      = r_slot;
    assign locked    = (r_state == c_LOCKED);
    assign sync_err  = r_sync_err;

endmodule
`default_nettype wire

// File: doc/demux1to8_tdm.md
DEMUX1TO8_TDM -- requirements
Module: demux1to8_tdm

Interface
REQ-001 Parameters: none; frame is fixed at 8 one-bit slots.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 din  input  1  serial TDM data bit for the current slot.
REQ-005 din_valid  input  1  din is accepted this cycle when high.
REQ-006 frame_sync  input  1  qualified by din_valid; marks din as slot 0 of a frame.
REQ-007 out  output  8  last completed frame; out[k] = bit received in slot k; registered.
REQ-008 out_valid  output  1  one-cycle pulse when out updates.
REQ-009 slot  output  3  slot index the next accepted bit will occupy; registered.
REQ-010 locked  output  1  high in LOCKED state.
REQ-011 sync_err  output  1  one-cycle pulse on frame alignment error.

Function
REQ-012 FSM states: HUNT, LOCKED; reset state HUNT.
REQ-013 HUNT: bits with frame_sync low are discarded; slot holds 0.
REQ-014 HUNT -> LOCKED on din_valid & frame_sync; that din is stored as shadow bit 0; slot becomes 1.
REQ-015 LOCKED: each din_valid cycle stores din into shadow[slot]; slot increments modulo 8.
REQ-016 Cycles with din_valid low change no state; slot, shadow, out hold.
REQ-017 On the accepted bit at slot 7: on the next edge, out = {din, shadow[6:0]} and out_valid = 1 for exactly one cycle; slot wraps to 0.
REQ-018 Latency: out/out_valid visible 1 cycle after slot-7 bit is accepted.
REQ-019 LOCKED, din_valid & frame_sync at slot != 0: sync_err pulses 1 cycle; partial frame discarded (out unchanged, no out_valid); din stored as slot 0; slot becomes 1; stay LOCKED.
REQ-020 LOCKED, din_valid & frame_sync at slot 0: normal frame start, no error.
REQ-021 out holds its value between frames; a new frame overwrites it only at completion.
REQ-022 Back-to-back frames with din_valid continuously high yield out_valid every 8 cycles, no gaps.
REQ-023 Slot-7 and a frame_sync (error) are exclusive by definition; frame_sync at slot 7 is treated as REQ-019.

Reset
REQ-024 rst high at any edge: state HUNT, slot 0, out 8'h00, out_valid 0, sync_err 0, locked 0, shadow cleared.
REQ-025 rst mid-frame discards the partial frame; no out_valid is produced for it.
REQ-026 rst has priority over all inputs in the same cycle.

Configuration
REQ-027 Macro DEMUX_SYNC_STRICT_EN.
REQ-028 Defined: in LOCKED, din_valid at slot 0 with frame_sync low pulses sync_err, discards the bit, moves to HUNT, slot 0.
REQ-029 Not defined: flywheel mode; frame_sync at slot 0 is optional once LOCKED; that bit is accepted as slot 0.
REQ-030 All other behaviour is identical in both builds.

Verification
REQ-031 Reset, then 8 valid bits with frame_sync on first, din LSB-first of 8'hA5 -> out=8'hA5, out_valid pulse 1 cycle after 8th bit, locked=1.
REQ-032 Bits with frame_sync low after reset -> out stays 8'h00, locked=0, no out_valid.
REQ-033 Frame 8'h3C with din_valid low gaps of 2 cycles between bits -> out=8'h3C, single out_valid, slot holds during gaps.
REQ-034 frame_sync at slot 4 -> sync_err pulse, no out_valid; following 8 bits 8'hF0 -> out=8'hF0.
REQ-035 Two back-to-back frames 8'h01, 8'h80, second without frame_sync -> flywheel: out_valid twice 8 cycles apart, out=8'h80; DEMUX_SYNC_STRICT_EN: sync_err at second slot 0, locked=0, out stays 8'h01.
REQ-036 rst asserted at slot 5 -> out=8'h00, slot=0, locked=0 next cycle, no out_valid.
